hop_add_map: RTL and testbench

- Downstream stage of the hop-selection kernel; consumes the 5-bit PERM5 output.
- Computes the channel-register index as (perm_out + E + F + Y2) mod 79.
- Maps that index through the 79-entry register bank: even RF channels first, then odd RF channels.
- Two-stage pipeline with valid/ready on both sides, plus an accepted-output counter and a synchronous flush.

---
 rtl/hop_add_map.sv | 140 ++++++++++++++
 tb/tb_hop_add_map.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hop_add_map.sv
// -----------------------------------------------------------------------------
// hop_add_map
//   Final stage of the hop-selection kernel. Adds the PERM5 result to the E, F
//   and Y2 operands and reduces the sum mod NUM_CH to a register-bank index.
//   That index is then mapped to an RF channel: the bank holds the even
//   channels first, then the odd ones.
//
//   Pipeline:  S1 = index register,  S2 = output register (channel + index).
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   flush      : synchronous clear of both pipeline stages
//   in_valid   : upstream operand set valid
//   in_ready   : this block accepts an operand set this cycle
//   perm_in    : PERM5 output (5 bits)
//   e_in       : E operand (7 bits)
//   f_in       : F operand (7 bits; any value legal)
//   y2_in      : Y2 operand (6 bits; any value legal)
//   out_valid  : chan_out / idx_out valid
//   out_ready  : downstream accepts chan_out
//   chan_out   : RF channel number, 0..NUM_CH-1
//   idx_out    : register-bank index that produced chan_out
//   hop_cnt    : count of completed output transfers (wraps)
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. A producer holds valid and data stable until the transfer. in_ready is
// derived from pipeline state and out_ready only; it never depends on in_valid.
// -----------------------------------------------------------------------------
module hop_add_map #(
  parameter int NUM_CH = 79,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       perm_in,
  input  logic [6:0]       e_in,
  input  logic [6:0]       f_in,
  input  logic [5:0]       y2_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [6:0]       chan_out,
  output logic [6:0]       idx_out,
  output logic [CNT_W-1:0] hop_cnt
);

  localparam logic [8:0] MOD9 = 9'(NUM_CH);
  // Size of the even half of the bank (channels 0, 2, ..., 78 -> 40 entries).
  localparam logic [6:0] HALF = 7'((NUM_CH + 1) / 2);

  // Pipeline state
  logic             s1_valid_q, s1_valid_d;
  logic [6:0]       s1_idx_q,   s1_idx_d;
  logic             s2_valid_q, s2_valid_d;
  logic [6:0]       s2_idx_q,   s2_idx_d;
  logic [6:0]       s2_chan_q,  s2_chan_d;
  logic [CNT_W-1:0] cnt_q,      cnt_d;

  // Flow control
  logic s2_adv;
  logic s1_to_s2;
  logic in_xfer;
  logic out_xfer;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_to_s2 = s1_valid_q && s2_adv;
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = s2_valid_q && out_ready;

  // Stage 1: 9-bit sum (max 348 < 5*79), reduced by at most four conditional
  // subtractions of the modulus.
  logic [8:0] sum;
  logic [8:0] rem;

  assign sum = {4'b0, perm_in} + {2'b0, e_in} + {2'b0, f_in} + {3'b0, y2_in};

  always_comb begin
    rem = sum;
    for (int k = 0; k < 4; k++) begin
      if (rem >= MOD9) rem = rem - MOD9;
    end
  end

  always_comb begin
    s1_idx_d   = in_xfer ? rem[6:0] : s1_idx_q;
    s1_valid_d = s1_valid_q;
    if (flush)         s1_valid_d = 1'b0;
    else if (in_xfer)  s1_valid_d = 1'b1;
    else if (s1_to_s2) s1_valid_d = 1'b0;
  end

  // Stage 2: bank lookup. Lower half holds even channels, upper half odd ones.
  logic [6:0] chan_map;

  always_comb begin
    if (s1_idx_q < HALF) chan_map = s1_idx_q << 1;
    else                 chan_map = ((s1_idx_q - HALF) << 1) + 7'd1;
  end

  always_comb begin
    s2_idx_d   = s1_to_s2 ? s1_idx_q : s2_idx_q;
    s2_chan_d  = s1_to_s2 ? chan_map : s2_chan_q;
    s2_valid_d = s2_valid_q;
    if (flush)       s2_valid_d = 1'b0;
    else if (s2_adv) s2_valid_d = s1_valid_q;
  end

  // Output-transfer counter; flush does not touch it.
  always_comb begin
    cnt_d = out_xfer ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_idx_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_idx_q   <= '0;
      s2_chan_q  <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_idx_q   <= s1_idx_d;
      s2_valid_q <= s2_valid_d;
      s2_idx_q   <= s2_idx_d;
      s2_chan_q  <= s2_chan_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign chan_out  = s2_chan_q;
  assign idx_out   = s2_idx_q;
  assign hop_cnt   = cnt_q;

endmodule

// File: tb/tb_hop_add_map.sv
// -----------------------------------------------------------------------------
// tb_hop_add_map
//   Scoreboard bench for hop_add_map. The driver pushes the expected
//   {index, channel} of every accepted operand set into exp_q; the monitor pops
//   and compares on every output transfer, and tracks hop_cnt and stall
//   stability independently.
// -----------------------------------------------------------------------------
module tb_hop_add_map;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  perm_in;
  logic [6:0]  e_in;
  logic [6:0]  f_in;
  logic [5:0]  y2_in;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  chan_out;
  logic [6:0]  idx_out;
  logic [15:0] hop_cnt;

  hop_add_map #(.NUM_CH(79), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .perm_in   (perm_in),
    .e_in      (e_in),
    .f_in      (f_in),
    .y2_in     (y2_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .chan_out  (chan_out),
    .idx_out   (idx_out),
    .hop_cnt   (hop_cnt)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  logic [13:0] exp_q[$];      // {idx[6:0], chan[6:0]}
  int          bank[$];       // register bank: even channels then odd
  int          total = 0;
  int          bad   = 0;
  logic        sweep_on = 1'b0;
  logic        rand_rdy = 1'b0;
  int          seen[79];

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s act=%0d required=%0d t=%0t", nm, act, req, $time);
    end
  endtask

  // Reference: plain modulo and a table lookup in the bank list.
  function automatic logic [13:0] model(input int p, input int e, input int f, input int y);
    int s;
    int i;
    s = p + e + f + y;
    i = s % 79;
    return {7'(i), 7'(bank[i])};
  endfunction

  // ---------------- monitor ----------------
  logic [15:0] exp_cnt = '0;
  logic        prev_stall = 1'b0;
  logic [6:0]  prev_chan, prev_idx;

  initial begin
    logic [13:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_cnt    = '0;
        prev_stall = 1'b0;
      end else begin
        chk("hop_cnt", int'(hop_cnt), int'(exp_cnt));
        if (prev_stall) begin
          chk("stall_valid", int'(out_valid), 1);
          chk("stall_chan", int'(chan_out), int'(prev_chan));
          chk("stall_idx", int'(idx_out), int'(prev_idx));
        end
        if (out_valid && out_ready) begin
          exp_cnt = exp_cnt + 16'd1;
          if (exp_q.size() == 0) begin
            chk("unexpected_output", 1, 0);
          end else begin
            e = exp_q.pop_front();
            chk("idx_out", int'(idx_out), int'(e[13:7]));
            chk("chan_out", int'(chan_out), int'(e[6:0]));
          end
          if (sweep_on && chan_out < 7'd79) seen[chan_out]++;
        end
        prev_stall = out_valid && !out_ready && !flush;
        prev_chan  = chan_out;
        prev_idx   = idx_out;
      end
    end
  end

  // Random back-pressure source
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int p, input int e, input int f, input int y);
    logic ok;
    logic fl;
    int   n;
    perm_in  = 5'(p);
    e_in     = 7'(e);
    f_in     = 7'(f);
    y2_in    = 6'(y);
    in_valid = 1'b1;
    n  = 0;
    ok = 1'b0;
    fl = 1'b0;
    forever begin
      @(negedge clk);
      ok = in_ready;
      fl = flush;
      @(posedge clk);
      if (ok) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 0, 1);
        break;
      end
    end
    if (ok && !fl && rst_n) exp_q.push_back(model(p, e, f, y));
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 1000) chk("drain_timeout", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Single operand on an empty pipeline: checks the two-cycle latency.
  task automatic single(input int p, input int e, input int f, input int y,
                        input int ei, input int ec);
    out_ready = 1'b1;
    send(p, e, f, y);
    @(negedge clk);
    chk("lat_n1_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("lat_n2_valid", int'(out_valid), 1);
    chk("dir_idx", int'(idx_out), ei);
    chk("dir_chan", int'(chan_out), ec);
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [15:0] cnt0;
    for (int c = 0; c < 79; c += 2) bank.push_back(c);
    for (int c = 1; c < 79; c += 2) bank.push_back(c);
    for (int c = 0; c < 79; c++) seen[c] = 0;

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    perm_in   = '0;
    e_in      = '0;
    f_in      = '0;
    y2_in     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_chan", int'(chan_out), 0);
    chk("rst_idx", int'(idx_out), 0);
    chk("rst_hop_cnt", int'(hop_cnt), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed values
    single(5, 10, 20, 0, 35, 70);
    chk("hop_cnt_first", int'(hop_cnt), 1);
    single(31, 127, 78, 32, 31, 62);
    single(31, 127, 127, 63, 32, 64);
    single(0, 79, 0, 0, 0, 0);
    single(0, 39, 0, 0, 39, 78);
    single(0, 40, 0, 0, 40, 1);
    single(0, 78, 0, 0, 78, 77);

    // Sweep the bank: every channel exactly once
    sweep_on  = 1'b1;
    out_ready = 1'b1;
    for (int e = 0; e < 79; e++) send(0, e, 0, 0);
    drain();
    sweep_on = 1'b0;
    for (int c = 0; c < 79; c++) chk($sformatf("sweep_ch%0d", c), seen[c], 1);

    // Back-pressure: out_ready low in cycles 2..5 of a 6-operand stream
    cnt0 = hop_cnt;
    out_ready = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) send(i, 10 * i + 3, 70 - i, 32);
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        for (int k = 3; k <= 5; k++) begin
          @(negedge clk);
          chk("bp_in_ready", int'(in_ready), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_hop_cnt", int'(hop_cnt), int'(cnt0 + 16'd6));

    // Flush with two entries in flight and no downstream acceptance
    out_ready = 1'b0;
    send(7, 8, 9, 0);
    send(1, 2, 3, 32);
    cnt0  = hop_cnt;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_out_valid", int'(out_valid), 0);
    @(negedge clk);
    chk("flush_out_valid2", int'(out_valid), 0);
    chk("flush_hop_cnt", int'(hop_cnt), int'(cnt0));
    @(posedge clk);
    #1;
    single(5, 10, 20, 0, 35, 70);

    // Randomized traffic with random back-pressure
    rand_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      send($urandom_range(0, 31), $urandom_range(0, 127),
           $urandom_range(0, 127), $urandom_range(0, 63));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
    end
    drain();
    rand_rdy = 1'b0;
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Asynchronous reset mid-stream, between clock edges
    send(3, 4, 5, 6);
    send(9, 100, 50, 32);
    rst_n = 1'b0;
    #2;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_hop_cnt", int'(hop_cnt), 0);
    chk("arst_chan", int'(chan_out), 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    single(31, 127, 127, 63, 32, 64);
    chk("arst_hop_after", int'(hop_cnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
